// File: rtl/mem_load_collect_pkg.sv
// Shared types for the MEM-stage load-return collector.
package mem_load_collect_pkg;

    typedef enum logic [2:0] {
        OpLdb  = 3'd0,
        OpLdbu = 3'd1,
        OpLdh  = 3'd2,
        OpLdhu = 3'd3,
        OpLdw  = 3'd4,
        OpLlw  = 3'd5
    } load_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone,
        StDrain
    } collect_state_t;

    localparam int unsigned MaxLanes = 4;
    localparam int unsigned MaxLaneW = 2;

    // Wide enough for any legal lane count; narrower tags are zero-extended.
    typedef logic [MaxLaneW-1:0] lane_tag_t;

endpackage

// File: rtl/mem_load_collect_load_align.sv
// Combinational load-result alignment and sign/zero extension.
module mem_load_collect_load_align
    import mem_load_collect_pkg::*;
(
    input  load_op_t    op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        half_ok;

    always_comb begin
        unique case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Odd halfword offsets are trapped upstream; return zero here.
        half_ok  = ~offset_i[0];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = '0;
        case (op_i)
            OpLdb:        result_o = {{24{byte_sel[7]}}, byte_sel};
            OpLdbu:       result_o = {24'b0, byte_sel};
            OpLdh:        if (half_ok) result_o = {{16{half_sel[15]}}, half_sel};
            OpLdhu:       if (half_ok) result_o = {16'b0, half_sel};
            OpLdw, OpLlw: result_o = word_i;
            default:      result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_collect.sv
// Per-lane dcache load-return collector: holds MEM until every live load has
// returned, and drains in-flight responses after a flush.
module mem_load_collect
    import mem_load_collect_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    input  logic                advance_i,
    input  logic                flush_i,
    input  logic [LANES-1:0]    lane_load_i,
    input  logic [LANES*3-1:0]  lane_op_i,
    input  logic [LANES*2-1:0]  lane_off_i,
    input  logic [LANES-1:0]    lane_excp_i,
    input  logic [LANES*DATA_W-1:0] lane_pass_i,
    input  logic                resp_valid_i,
    input  logic [LW-1:0]       resp_lane_i,
    input  logic [DATA_W-1:0]   resp_data_i,
    output logic [LANES*DATA_W-1:0] wdata_o,
    output logic                out_valid_o,
    output logic                pause_o,
    output logic                spurious_o
);

    localparam int unsigned CntW = $clog2(2 * LANES + 1);
    typedef logic [CntW-1:0] cnt_t;

    collect_state_t    state_q, state_d;
    logic [LANES-1:0]  pending_q, pending_d;
    cnt_t              drain_cnt_q, drain_cnt_d, flush_cnt;
    logic [DATA_W-1:0] lane_buf_q [LANES];
    logic [DATA_W-1:0] lane_buf_d [LANES];
    load_op_t          op_q [LANES];
    load_op_t          op_d [LANES];
    logic [1:0]        off_q [LANES];
    logic [1:0]        off_d [LANES];
    logic              spurious_q, spurious_d;

    logic [LANES-1:0]  live, hit_mask, remaining;
    logic              resp_hit, resp_drained, last_hit;
    lane_tag_t         resp_tag;
    load_op_t          resp_op;
    logic [1:0]        resp_off;
    logic [DATA_W-1:0] aligned;

    assign resp_tag = lane_tag_t'(resp_lane_i);

    // A lane is live only if no older-or-same lane carries an exception.
    always_comb begin
        logic excp_seen;
        excp_seen = 1'b0;
        live      = '0;
        for (int i = 0; i < LANES; i++) begin
            excp_seen = excp_seen | lane_excp_i[i];
            live[i]   = lane_load_i[i] & ~excp_seen;
        end
    end

    always_comb begin
        hit_mask = '0;
        resp_op  = OpLdw;
        resp_off = '0;
        for (int i = 0; i < LANES; i++) begin
            if (resp_tag == lane_tag_t'(i)) begin
                resp_op     = op_q[i];
                resp_off    = off_q[i];
                hit_mask[i] = resp_valid_i & pending_q[i] & (state_q == StWait);
            end
        end
    end

    mem_load_collect_load_align u_load_align (
        .op_i     (resp_op),
        .offset_i (resp_off),
        .word_i   (resp_data_i),
        .result_o (aligned)
    );

    assign resp_hit     = |hit_mask;
    assign remaining    = pending_q & ~hit_mask;
    assign last_hit     = (state_q == StWait) & resp_hit & (remaining == '0);
    assign resp_drained = (state_q == StDrain) & resp_valid_i & (drain_cnt_q != '0);

    assign pause_o     = (state_q == StWait) & (remaining != '0);
    assign out_valid_o = (state_q == StDone) | last_hit;
    assign spurious_o  = spurious_q;

    // The final response bypasses its buffer so completion costs no bubble.
    always_comb begin
        wdata_o = '0;
        for (int i = 0; i < LANES; i++) begin
            wdata_o[i*DATA_W +: DATA_W] = (last_hit & hit_mask[i]) ? aligned : lane_buf_q[i];
        end
    end

    always_comb begin
        flush_cnt = drain_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            flush_cnt = flush_cnt + cnt_t'(pending_q[i]);
        end
        flush_cnt = flush_cnt - cnt_t'(resp_hit | resp_drained);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        drain_cnt_d = drain_cnt_q;
        lane_buf_d  = lane_buf_q;
        op_d        = op_q;
        off_d       = off_q;
        spurious_d  = spurious_q | (resp_valid_i & ~resp_hit & (state_q != StDrain));

        if (flush_i) begin
            pending_d   = '0;
            drain_cnt_d = flush_cnt;
            state_d     = (flush_cnt != '0) ? StDrain : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        pending_d = live;
                        for (int i = 0; i < LANES; i++) begin
                            lane_buf_d[i] = lane_load_i[i] ? '0 : lane_pass_i[i*DATA_W +: DATA_W];
                            op_d[i]       = load_op_t'(lane_op_i[3*i +: 3]);
                            off_d[i]      = lane_off_i[2*i +: 2];
                        end
                        state_d = (live != '0) ? StWait : StDone;
                    end
                end
                StWait: begin
                    if (resp_hit) begin
                        pending_d = remaining;
                        for (int i = 0; i < LANES; i++) begin
                            if (hit_mask[i]) lane_buf_d[i] = aligned;
                        end
                        if (remaining == '0) state_d = advance_i ? StIdle : StDone;
                    end
                end
                StDone: begin
                    if (advance_i) state_d = StIdle;
                end
                StDrain: begin
                    if (resp_drained) drain_cnt_d = drain_cnt_q - cnt_t'(1);
                    if (drain_cnt_d == '0) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            drain_cnt_q <= '0;
            spurious_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_buf_q[i] <= '0;
                op_q[i]       <= OpLdb;
                off_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            drain_cnt_q <= drain_cnt_d;
            spurious_q  <= spurious_d;
            lane_buf_q  <= lane_buf_d;
            op_q        <= op_d;
            off_q       <= off_d;
        end
    end

endmodule

// File: tb/tb_mem_load_collect.sv
// Self-checking bench for mem_load_collect with LANES=2, DATA_W=32.
module tb_mem_load_collect;
    import mem_load_collect_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, advance, flush;
    logic [1:0]  lane_load, lane_excp;
    logic [5:0]  lane_op;
    logic [3:0]  lane_off;
    logic [63:0] lane_pass;
    logic        resp_valid;
    logic [0:0]  resp_lane;
    logic [31:0] resp_data;
    logic [63:0] wdata;
    logic        out_valid, pause, spurious;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    mem_load_collect #(
        .LANES  (2),
        .DATA_W (32),
        .LW     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .advance_i    (advance),
        .flush_i      (flush),
        .lane_load_i  (lane_load),
        .lane_op_i    (lane_op),
        .lane_off_i   (lane_off),
        .lane_excp_i  (lane_excp),
        .lane_pass_i  (lane_pass),
        .resp_valid_i (resp_valid),
        .resp_lane_i  (resp_lane),
        .resp_data_i  (resp_data),
        .wdata_o      (wdata),
        .out_valid_o  (out_valid),
        .pause_o      (pause),
        .spurious_o   (spurious)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid   = 1'b0;
        advance    = 1'b0;
        flush      = 1'b0;
        lane_load  = '0;
        lane_excp  = '0;
        lane_op    = '0;
        lane_off   = '0;
        lane_pass  = '0;
        resp_valid = 1'b0;
        resp_lane  = '0;
        resp_data  = '0;
    endtask

    // Returns 1 time unit after the active edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got 0x%0h, expected an entry in the scoreboard (empty)", name, wdata);
        end else begin
            exp = sb_q.pop_front();
            check(name, wdata, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_w;

        vecs[0]  = '{3'd0, 2'd3, 32'h80FF0000, 32'hFFFFFF80};
        vecs[1]  = '{3'd1, 2'd3, 32'h80FF0000, 32'h00000080};
        vecs[2]  = '{3'd2, 2'd2, 32'h80FF0000, 32'hFFFF80FF};
        vecs[3]  = '{3'd3, 2'd1, 32'h80FF0000, 32'h00000000};
        vecs[4]  = '{3'd4, 2'd0, 32'h12345678, 32'h12345678};
        vecs[5]  = '{3'd5, 2'd0, 32'h9ABCDEF0, 32'h9ABCDEF0};
        vecs[6]  = '{3'd0, 2'd0, 32'h0000007F, 32'h0000007F};
        vecs[7]  = '{3'd0, 2'd1, 32'h00008100, 32'hFFFFFF81};
        vecs[8]  = '{3'd3, 2'd2, 32'h80010000, 32'h00008001};
        vecs[9]  = '{3'd2, 2'd0, 32'h00007FFF, 32'h00007FFF};
        vecs[10] = '{3'd2, 2'd3, 32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{3'd1, 2'd2, 32'h00AB0000, 32'h000000AB};

        // Reset
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #3;
        check("rst_wdata", wdata, 64'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pause", pause, 1'b0);
        check("rst_spurious", spurious, 1'b0);
        check("rst_state", dut.state_q, StIdle);

        // Out-of-order returns, then WB backpressure
        tick();
        in_valid  = 1'b1;
        lane_load = 2'b11;
        lane_op   = {3'd4, 3'd4};
        tick();
        idle_inputs();
        #3;
        check("ooo_pause_entry", pause, 1'b1);
        check("ooo_valid_entry", out_valid, 1'b0);
        exp_w = {32'h11223344, 32'hAABBCCDD};
        sb_q.push_back(exp_w);
        tick();
        resp_valid = 1'b1;
        resp_lane  = 1'b1;
        resp_data  = 32'h11223344;
        #3;
        check("ooo_pause_first_resp", pause, 1'b1);
        check("ooo_valid_first_resp", out_valid, 1'b0);
        tick();
        resp_lane = 1'b0;
        resp_data = 32'hAABBCCDD;
        #3;
        check("ooo_pause_last_resp", pause, 1'b0);
        check("ooo_valid_bypass", out_valid, 1'b1);
        sb_check("ooo_bypass_wdata");
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("bp_valid_%0d", c), out_valid, 1'b1);
            check($sformatf("bp_wdata_%0d", c), wdata, exp_w);
            tick();
        end
        advance = 1'b1;
        #3;
        check("bp_valid_advance", out_valid, 1'b1);
        tick();
        idle_inputs();
        #3;
        check("bp_idle_valid", out_valid, 1'b0);
        check("bp_idle_state", dut.state_q, StIdle);
        in_valid  = 1'b1;
        lane_pass = {32'h0, 32'h5};
        tick();
        idle_inputs();
        #3;
        check("pass_valid", out_valid, 1'b1);
        check("pass_wdata", wdata, {32'h0, 32'h5});
        advance = 1'b1;
        tick();
        idle_inputs();

        // Extension table: lane0 load, lane1 non-load pass-through
        for (int k = 0; k < NV; k++) begin
            in_valid  = 1'b1;
            lane_load = 2'b01;
            lane_op   = {3'd0, vecs[k].op};
            lane_off  = {2'd0, vecs[k].off};
            lane_pass = {32'h0000CAFE, 32'h0000DEAD};
            sb_q.push_back({32'h0000CAFE, vecs[k].exp});
            tick();
            idle_inputs();
            resp_valid = 1'b1;
            resp_lane  = 1'b0;
            resp_data  = vecs[k].word;
            advance    = 1'b1;
            #3;
            check($sformatf("tbl%0d_valid", k), out_valid, 1'b1);
            sb_check($sformatf("tbl%0d_wdata", k));
            tick();
            idle_inputs();
        end
        #3;
        check("tbl_back_idle", dut.state_q, StIdle);
        check("tbl_sb_empty", 64'(sb_q.size()), 64'd0);

        // Flush in the same cycle as the lane0 response
        tick();
        in_valid  = 1'b1;
        lane_load = 2'b11;
        lane_op   = {3'd4, 3'd4};
        tick();
        idle_inputs();
        resp_valid = 1'b1;
        resp_lane  = 1'b0;
        resp_data  = 32'h01234567;
        flush      = 1'b1;
        tick();
        idle_inputs();
        #3;
        check("flush_drain_cnt", 64'(dut.drain_cnt_q), 64'd1);
        check("flush_state", dut.state_q, StDrain);
        check("flush_pause", pause, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        tick();
        resp_valid = 1'b1;
        resp_lane  = 1'b1;
        resp_data  = 32'h76543210;
        in_valid   = 1'b1;
        lane_pass  = {32'h0, 32'h42};
        #3;
        check("drain_valid", out_valid, 1'b0);
        tick();
        idle_inputs();
        #3;
        check("drain_done_state", dut.state_q, StIdle);
        check("drain_done_cnt", 64'(dut.drain_cnt_q), 64'd0);
        check("drain_no_spurious", spurious, 1'b0);
        check("drain_bundle_ignored", out_valid, 1'b0);
        in_valid  = 1'b1;
        lane_pass = {32'h0, 32'h42};
        tick();
        idle_inputs();
        #3;
        check("post_drain_valid", out_valid, 1'b1);
        check("post_drain_wdata", wdata, {32'h0, 32'h42});
        advance = 1'b1;
        tick();
        idle_inputs();

        // Precise cancel: lane0 excepts, lane1 load is cancelled
        in_valid  = 1'b1;
        lane_excp = 2'b01;
        lane_load = 2'b10;
        lane_op   = {3'd4, 3'd0};
        lane_pass = {32'h99, 32'h77};
        tick();
        idle_inputs();
        #3;
        check("cancel_state", dut.state_q, StDone);
        check("cancel_pause", pause, 1'b0);
        check("cancel_valid", out_valid, 1'b1);
        check("cancel_wdata", wdata, {32'h0, 32'h77});
        advance = 1'b1;
        tick();
        idle_inputs();
        resp_valid = 1'b1;
        resp_lane  = 1'b1;
        resp_data  = 32'hDEADBEEF;
        tick();
        idle_inputs();
        #3;
        check("cancel_spurious", spurious, 1'b1);
        tick();
        #3;
        check("spurious_sticky", spurious, 1'b1);

        // Reset while waiting on two loads
        tick();
        in_valid  = 1'b1;
        lane_load = 2'b11;
        lane_op   = {3'd4, 3'd4};
        tick();
        idle_inputs();
        #3;
        check("midrst_pause_before", pause, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #3;
        check("midrst_wdata", wdata, 64'h0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_pause", pause, 1'b0);
        check("midrst_spurious", spurious, 1'b0);
        check("midrst_state", dut.state_q, StIdle);
        check("midrst_drain_cnt", 64'(dut.drain_cnt_q), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
